sine_voice_sched: RTL and testbench
===================================

# sine_voice_sched

Time-multiplexed scheduler that shares one synchronous sine lookup RAM (32 x 24-bit, 1-cycle read latency) among `voices_p` oscillator voices. On each sample tick it steps every voice's phase accumulator, reads one LUT entry per voice in sequence, and averages the results into a mixed sample. It then delivers that sample as a left/right pair over a valid/ready stream to the I2S transmit path. It sits between the sine LUT instance and the `axis_i2s2` TX channel.

## Interface
- `voices_p`, 4, number of voices; power of two, 2..8
- `width_p`, 24, sample width; LUT data is signed two's complement
- `phase_width_p`, 32, phase accumulator width
- `addr_width_p`, 5, LUT address width; address = top `addr_width_p` bits of phase
- `clk_i`  in  1  single clock for all logic
- `reset_i`  in  1  synchronous, active-high reset
- `sample_tick_i`  in  1  one-cycle pulse requesting one stereo frame
- `enable_i`  in  voices_p  per-voice enable
- `step_i`  in  voices_p*phase_width_p  per-voice frequency step; voice k uses bits [k*phase_width_p +: phase_width_p]
- `lut_addr_o`  out  addr_width_p  LUT read address
- `lut_data_i`  in  width_p  LUT read data, valid the cycle after its address
- `tx_data_o`  out  width_p  mixed sample
- `tx_valid_o`  out  1  stream valid
- `tx_ready_i`  in  1  stream ready
- `tx_last_o`  out  1  1 on the right-channel word
- `busy_o`  out  1  high in any state other than IDLE
- `overrun_o`  out  1  sticky; set when a tick arrives while busy; cleared only by reset

## Operation
- States: IDLE, ISSUE, DRAIN, SEND_L, SEND_R.
- IDLE: `lut_addr_o` = 0. When `sample_tick_i` = 1, clear the accumulator, set the voice index to 0, and go to ISSUE.
- ISSUE, one cycle per voice, index 0..voices_p-1:
  - `lut_addr_o` = phase[idx][phase_width_p-1 -: addr_width_p], driven combinationally from the registered phase.
  - At the end of the cycle: if `enable_i[idx]`, phase[idx] += step[idx] (modulo 2^phase_width_p, wraps silently); otherwise phase[idx] <= 0, so an enabled voice restarts at phase 0.
  - After the last index, go to DRAIN.
- Accumulate: each cycle after an ISSUE cycle, add `lut_data_i` to the accumulator, sign-extended to width_p+log2(voices_p) bits. Add 0 if that voice's enable was low when its address was issued; the enable is registered alongside the index.
- DRAIN: accumulate the last voice. Register mix = accumulator >>> log2(voices_p) (arithmetic shift, truncates toward -inf) into `tx_data_o`. Go to SEND_L.
- SEND_L: `tx_valid_o` = 1, `tx_last_o` = 0. On `tx_ready_i` go to SEND_R.
- SEND_R: `tx_valid_o` = 1, `tx_last_o` = 1, same `tx_data_o`. On `tx_ready_i` go to IDLE.
- Ticks while busy are dropped and set `overrun_o`. A tick in the same cycle as the SEND_R handshake is also dropped and sets overrun.
- `tx_data_o` holds its value after SEND_R until the next DRAIN.
- `enable_i` and `step_i` are sampled per voice only in that voice's ISSUE cycle.
- `tx_data_o` and `tx_last_o` must not change while `tx_valid_o` = 1 and `tx_ready_i` = 0.

## Timing
- Reset values: state IDLE, all phases 0, accumulator 0, `lut_addr_o` 0, `tx_data_o` 0, `tx_valid_o` 0, `tx_last_o` 0, `busy_o` 0, `overrun_o` 0.
- Reset mid-frame aborts immediately. The next cycle shows reset values and no partial handshake completes.
- With the tick sampled at cycle t:
  - ISSUE occupies cycles t+1..t+voices_p.
  - DRAIN is at cycle t+voices_p+1.
  - `tx_valid_o` first rises at t+voices_p+2, which is 6 cycles for voices_p = 4.
- Minimum frame time is voices_p+4 cycles with `tx_ready_i` held high. Tick period must be at least this to avoid overrun.
- `busy_o` is high from t+1 until the cycle after the SEND_R handshake.

## Test plan
- Bench setup: LUT model loaded with lut[k] = k*0x001000; voices_p = 4; `tx_ready_i` = 1.
- Reset, then one tick with voice 0 enabled, step 0x0800_0000, others disabled. Required: addresses 0,0,0,0 issued; L then R words = 0x000000; `tx_last_o` 0 then 1; valid first high 6 cycles after the tick.
- Same setup, 33 ticks spaced 12 cycles apart. Required: voice-0 address sequence 0,1,2,…,31,0 (wrap); frame n outputs (n mod 32)*0x001000 >>> 2 = (n mod 32)*0x000400.
- All four voices enabled, steps 0x0800_0000 / 0x1000_0000 / 0x1800_0000 / 0x2000_0000, 2 ticks. Required: second-frame addresses 1,2,3,4; mix = (1+2+3+4)*0x1000/4 = 0x002800.
- LUT entries negative (lut[k] = 0xFFF000 for all k), all voices enabled. Required: mix = 0xFFF000 exactly, sign preserved.
- `tx_ready_i` low for 10 cycles in SEND_L. Required: `tx_valid_o`, `tx_data_o` and `tx_last_o` stable. A tick during the stall sets `overrun_o`, which stays 1 afterward. The frame completes normally once ready rises.
- Reset asserted during ISSUE of voice 2. Required: next cycle all outputs at reset values; the following tick restarts at phase 0 for every voice.

Source files
------------

// File: rtl/sine_voice_sched.sv
// sine_voice_sched
// Shares one synchronous sine LUT (1-cycle read latency) among voices_p
// oscillator voices. Each sample tick steps every voice's phase accumulator,
// reads one LUT entry per voice, averages the entries and then presents the
// mixed sample twice (left, then right) on a valid/ready stream.
//
// Frame timeline, tick sampled at cycle t:
//   t+1 .. t+voices_p : ISSUE, one LUT address per voice
//   t+voices_p+1      : DRAIN, last LUT word accumulated, mix registered
//   t+voices_p+2 ..   : SEND_L then SEND_R, each held until tx_ready_i

module sine_voice_sched #(
   parameter int voices_p      = 4,
   parameter int width_p       = 24,
   parameter int phase_width_p = 32,
   parameter int addr_width_p  = 5
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic                               sample_tick_i,
   input  logic [voices_p-1:0]                enable_i,
   input  logic [voices_p*phase_width_p-1:0]  step_i,
   output logic [addr_width_p-1:0]            lut_addr_o,
   input  logic [width_p-1:0]                 lut_data_i,
   output logic [width_p-1:0]                 tx_data_o,
   output logic                               tx_valid_o,
   input  logic                               tx_ready_i,
   output logic                               tx_last_o,
   output logic                               busy_o,
   output logic                               overrun_o
);

   // Voice index width doubles as the averaging shift (voices_p is a power of two).
   localparam int idx_w = $clog2(voices_p);
   // Accumulator wide enough to sum voices_p full-scale signed samples.
   localparam int acc_w = width_p + idx_w;

   localparam logic [idx_w-1:0] last_idx = idx_w'(voices_p - 1);

   // Controller states.
   localparam logic [2:0] state_idle   = 3'd0;
   localparam logic [2:0] state_issue  = 3'd1;
   localparam logic [2:0] state_drain  = 3'd2;
   localparam logic [2:0] state_send_l = 3'd3;
   localparam logic [2:0] state_send_r = 3'd4;

   logic [2:0]               state;
   logic [2:0]               state_next;
   logic [idx_w-1:0]         idx;
   logic [phase_width_p-1:0] phase [voices_p];
   logic [phase_width_p-1:0] step_arr [voices_p];
   logic [phase_width_p-1:0] cur_phase;
   logic [phase_width_p-1:0] cur_step;
   logic                     cur_en;

   // LUT word pending: the previous cycle issued an address, and whether
   // that voice was enabled when it was issued.
   logic                     pend;
   logic                     pend_en;

   logic signed [acc_w-1:0]  acc;
   logic signed [acc_w-1:0]  data_ext;
   logic signed [acc_w-1:0]  addend;
   logic signed [acc_w-1:0]  acc_sum;

   logic [width_p-1:0]       tx_data;
   logic                     tx_valid;
   logic                     tx_last;
   logic                     busy;
   logic                     overrun;

   // Split the flat step bus into one word per voice.
   genvar g;
   generate
      for (g = 0; g < voices_p; g++) begin : g_step
         assign step_arr[g] = step_i[g*phase_width_p +: phase_width_p];
      end
   endgenerate

   // Select the per-voice operands for the voice currently being issued.
   always_comb begin
      cur_phase = phase[idx];
      cur_step  = step_arr[idx];
      cur_en    = enable_i[idx];
   end

   // LUT address: top phase bits of the active voice during ISSUE, else zero.
   always_comb begin
      if (state == state_issue) begin
         lut_addr_o = cur_phase[phase_width_p-1 -: addr_width_p];
      end else begin
         lut_addr_o = {addr_width_p{1'b0}};
      end
   end

   // Sign-extend the returned LUT word; muted voices contribute zero.
   always_comb begin
      data_ext = {{idx_w{lut_data_i[width_p-1]}}, lut_data_i};
      if (pend && pend_en) begin
         addend = data_ext;
      end else begin
         addend = {acc_w{1'b0}};
      end
      acc_sum = acc + addend;
   end

   // Next-state logic of the frame controller.
   always_comb begin
      state_next = state;
      case (state)
         state_idle: begin
            if (sample_tick_i) begin
               state_next = state_issue;
            end else begin
               state_next = state_idle;
            end
         end
         state_issue: begin
            if (idx == last_idx) begin
               state_next = state_drain;
            end else begin
               state_next = state_issue;
            end
         end
         state_drain: begin
            state_next = state_send_l;
         end
         state_send_l: begin
            if (tx_ready_i) begin
               state_next = state_send_r;
            end else begin
               state_next = state_send_l;
            end
         end
         state_send_r: begin
            if (tx_ready_i) begin
               state_next = state_idle;
            end else begin
               state_next = state_send_r;
            end
         end
         default: begin
            state_next = state_idle;
         end
      endcase
   end

   // State register, busy flag and sticky overrun flag.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state   <= state_idle;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != state_idle);
         // Any tick outside IDLE is dropped, including one coinciding
         // with the right-channel handshake.
         if (sample_tick_i && (state != state_idle)) begin
            overrun <= 1'b1;
         end else begin
            overrun <= overrun;
         end
      end
   end

   // Phase accumulators: advance an enabled voice, park a muted one at zero.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int k = 0; k < voices_p; k++) begin
            phase[k] <= {phase_width_p{1'b0}};
         end
      end else if (state == state_issue) begin
         if (cur_en) begin
            phase[idx] <= cur_phase + cur_step;
         end else begin
            phase[idx] <= {phase_width_p{1'b0}};
         end
      end else begin
         for (int k = 0; k < voices_p; k++) begin
            phase[k] <= phase[k];
         end
      end
   end

   // Voice index, pending-read tracking and the mix accumulator.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         idx     <= {idx_w{1'b0}};
         pend    <= 1'b0;
         pend_en <= 1'b0;
         acc     <= {acc_w{1'b0}};
      end else begin
         pend    <= (state == state_issue);
         pend_en <= (state == state_issue) && cur_en;
         case (state)
            state_idle: begin
               if (sample_tick_i) begin
                  idx <= {idx_w{1'b0}};
                  acc <= {acc_w{1'b0}};
               end else begin
                  idx <= idx;
                  acc <= acc;
               end
            end
            state_issue: begin
               // Index wraps back to zero after the last voice.
               idx <= idx + idx_w'(1);
               acc <= acc_sum;
            end
            state_drain: begin
               idx <= idx;
               acc <= acc_sum;
            end
            default: begin
               idx <= idx;
               acc <= acc;
            end
         endcase
      end
   end

   // Output stream registers: the mix is captured in DRAIN and held, with
   // valid/last stable, until each word is accepted.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tx_data  <= {width_p{1'b0}};
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
      end else begin
         case (state)
            state_drain: begin
               // Top width_p bits of the sum = arithmetic shift by idx_w,
               // rounding toward minus infinity.
               tx_data  <= acc_sum[acc_w-1:idx_w];
               tx_valid <= 1'b1;
               tx_last  <= 1'b0;
            end
            state_send_l: begin
               tx_data  <= tx_data;
               tx_valid <= 1'b1;
               if (tx_ready_i) begin
                  tx_last <= 1'b1;
               end else begin
                  tx_last <= 1'b0;
               end
            end
            state_send_r: begin
               tx_data <= tx_data;
               if (tx_ready_i) begin
                  tx_valid <= 1'b0;
                  tx_last  <= 1'b0;
               end else begin
                  tx_valid <= 1'b1;
                  tx_last  <= 1'b1;
               end
            end
            default: begin
               tx_data  <= tx_data;
               tx_valid <= 1'b0;
               tx_last  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data_o  = tx_data;
   assign tx_valid_o = tx_valid;
   assign tx_last_o  = tx_last;
   assign busy_o     = busy;
   assign overrun_o  = overrun;

endmodule

// File: tb/tb_sine_voice_sched.sv
// Directed bench for sine_voice_sched (4 voices, 24-bit LUT data).
// A frame-level reference model tracks every voice's phase and the expected
// stream words; a per-cycle compare process checks the DUT against it, and
// the directed tests pin literal hand-computed values.

module tb_sine_voice_sched;

   localparam int V = 4;

   logic          clk;
   logic          reset_i;
   logic          sample_tick_i;
   logic [3:0]    enable_i;
   logic [127:0]  step_i;
   logic [4:0]    lut_addr_o;
   logic [23:0]   lut_data_i;
   logic [23:0]   tx_data_o;
   logic          tx_valid_o;
   logic          tx_ready_i;
   logic          tx_last_o;
   logic          busy_o;
   logic          overrun_o;

   logic [23:0]   lut [32];

   int n_vec;
   int n_bad;

   sine_voice_sched #(
      .voices_p(4), .width_p(24), .phase_width_p(32), .addr_width_p(5)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .sample_tick_i(sample_tick_i),
      .enable_i(enable_i), .step_i(step_i), .lut_addr_o(lut_addr_o),
      .lut_data_i(lut_data_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
      .tx_ready_i(tx_ready_i), .tx_last_o(tx_last_o), .busy_o(busy_o),
      .overrun_o(overrun_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous LUT model: data one cycle after its address.
   always @(posedge clk) lut_data_i <= lut[lut_addr_o];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step_cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   bit          m_known;
   bit          m_active;
   int          m_cyc;
   int          m_sent;
   int          m_sum;
   logic [23:0] m_data;
   bit          m_over;
   logic [31:0] m_phase [V];

   initial begin : model_chk
      logic [4:0] a;
      logic       e;
      logic [4:0] exp_addr;
      bit         exp_valid;
      m_known = 0;
      forever begin
         @(negedge clk);
         if (m_known) begin
            exp_valid = m_active && (m_cyc >= V + 2);
            chk("busy", {31'd0, busy_o}, {31'd0, m_active});
            chk("valid", {31'd0, tx_valid_o}, {31'd0, exp_valid});
            chk("last", {31'd0, tx_last_o}, {31'd0, exp_valid && (m_sent == 1)});
            chk("data", {8'd0, tx_data_o}, {8'd0, m_data});
            chk("overrun", {31'd0, overrun_o}, {31'd0, m_over});
            if (!m_active || (m_cyc >= 1 && m_cyc <= V)) begin
               if (m_active) exp_addr = m_phase[m_cyc-1][31:27];
               else          exp_addr = 5'd0;
               chk("addr", {27'd0, lut_addr_o}, {27'd0, exp_addr});
            end
         end
         // advance the model with the inputs the coming edge will sample
         if (reset_i) begin
            m_known  = 1;
            m_active = 0;
            m_cyc    = 0;
            m_sent   = 0;
            m_sum    = 0;
            m_data   = 24'd0;
            m_over   = 0;
            for (int k = 0; k < V; k++) m_phase[k] = 32'd0;
         end else if (m_known) begin
            if (sample_tick_i && m_active) m_over = 1;
            if (m_active) begin
               if (m_cyc >= 1 && m_cyc <= V) begin
                  a = m_phase[m_cyc-1][31:27];
                  e = enable_i[m_cyc-1];
                  if (e) begin
                     m_sum = m_sum + int'($signed(lut[a]));
                     m_phase[m_cyc-1] = m_phase[m_cyc-1] + step_i[(m_cyc-1)*32 +: 32];
                  end else begin
                     m_phase[m_cyc-1] = 32'd0;
                  end
               end
               if (m_cyc == V + 1) m_data = 24'(m_sum >>> 2);
               if (m_cyc >= V + 2 && tx_ready_i) begin
                  m_sent++;
                  if (m_sent == 2) m_active = 0;
               end
               m_cyc++;
            end else if (sample_tick_i) begin
               m_active = 1;
               m_cyc    = 1;
               m_sent   = 0;
               m_sum    = 0;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // One frame with ready held high; returns issued addresses (voice k at
   // bits [5k +: 5]), the two stream words and their last flags.
   task automatic frame(output logic [19:0] a, output logic [23:0] dl, output logic [23:0] dr,
                        output logic ll, output logic lr);
      int lat;
      sample_tick_i = 1'b1;
      step_cyc();
      sample_tick_i = 1'b0;
      for (int k = 0; k < V; k++) begin
         a[k*5 +: 5] = lut_addr_o;
         step_cyc();
      end
      lat = V + 1;
      while (!tx_valid_o && lat < 30) begin
         step_cyc();
         lat++;
      end
      chk("valid_latency", lat, 6);
      dl = tx_data_o;
      ll = tx_last_o;
      step_cyc();
      dr = tx_data_o;
      lr = tx_last_o;
      step_cyc();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step_cyc();
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      idle(2);
      reset_i = 1'b0;
   endtask

   initial begin : stim
      logic [19:0] a;
      logic [23:0] dl, dr;
      logic        ll, lr;
      int          lat;
      n_vec = 0;
      n_bad = 0;
      for (int k = 0; k < 32; k++) lut[k] = 24'(k * 32'h1000);
      reset_i       = 1'b1;
      sample_tick_i = 1'b0;
      enable_i      = 4'b0000;
      step_i        = 128'd0;
      tx_ready_i    = 1'b1;
      idle(3);
      reset_i = 1'b0;
      idle(1);

      // Reset state.
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_valid", {31'd0, tx_valid_o}, 32'd0);
      chk("rst_data", {8'd0, tx_data_o}, 32'd0);

      // Test 1: single voice, single tick.
      enable_i = 4'b0001;
      step_i   = {32'd0, 32'd0, 32'd0, 32'h0800_0000};
      frame(a, dl, dr, ll, lr);
      chk("t1_addrs", {12'd0, a}, 32'd0);
      chk("t1_left", {8'd0, dl}, 32'd0);
      chk("t1_right", {8'd0, dr}, 32'd0);
      chk("t1_last_l", {31'd0, ll}, 32'd0);
      chk("t1_last_r", {31'd0, lr}, 32'd1);
      idle(4);

      // Test 2: 33 frames, voice-0 address walks 0..31 then wraps to 0.
      do_reset();
      for (int n = 0; n < 33; n++) begin
         frame(a, dl, dr, ll, lr);
         chk("t2_addr", {27'd0, a[4:0]}, 32'(n % 32));
         chk("t2_left", {8'd0, dl}, 32'((n % 32) * 32'h400));
         chk("t2_right", {8'd0, dr}, 32'((n % 32) * 32'h400));
         idle(4);
      end

      // Test 3: all voices, harmonic steps.
      do_reset();
      enable_i = 4'b1111;
      step_i   = {32'h2000_0000, 32'h1800_0000, 32'h1000_0000, 32'h0800_0000};
      frame(a, dl, dr, ll, lr);
      chk("t3_f0_addrs", {12'd0, a}, 32'd0);
      chk("t3_f0_mix", {8'd0, dl}, 32'd0);
      idle(4);
      frame(a, dl, dr, ll, lr);
      chk("t3_f1_addrs", {12'd0, a}, {12'd0, 5'd4, 5'd3, 5'd2, 5'd1});
      chk("t3_f1_mix", {8'd0, dl}, 32'h0000_2800);
      chk("t3_f1_right", {8'd0, dr}, 32'h0000_2800);
      idle(4);

      // Test 5: ready low for 10 cycles in SEND_L with a tick mid-stall.
      // Addresses 2,4,6,8 -> (2+4+6+8)*0x1000/4 = 0x5000.
      tx_ready_i    = 1'b0;
      sample_tick_i = 1'b1;
      step_cyc();
      sample_tick_i = 1'b0;
      lat = 1;
      while (!tx_valid_o && lat < 30) begin
         step_cyc();
         lat++;
      end
      chk("t5_latency", lat, 6);
      chk("t5_data", {8'd0, tx_data_o}, 32'h0000_5000);
      chk("t5_last", {31'd0, tx_last_o}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         step_cyc();
         sample_tick_i = 1'b0;
         chk("t5_stall_valid", {31'd0, tx_valid_o}, 32'd1);
         chk("t5_stall_data", {8'd0, tx_data_o}, 32'h0000_5000);
         chk("t5_stall_last", {31'd0, tx_last_o}, 32'd0);
         if (i == 3) sample_tick_i = 1'b1;
      end
      chk("t5_overrun", {31'd0, overrun_o}, 32'd1);
      tx_ready_i = 1'b1;
      step_cyc();
      chk("t5_right_last", {31'd0, tx_last_o}, 32'd1);
      chk("t5_right_data", {8'd0, tx_data_o}, 32'h0000_5000);
      step_cyc();
      chk("t5_done_valid", {31'd0, tx_valid_o}, 32'd0);
      chk("t5_done_busy", {31'd0, busy_o}, 32'd0);
      idle(3);
      chk("t5_overrun_sticky", {31'd0, overrun_o}, 32'd1);

      // Test 4: all LUT entries negative; mix must be exactly 0xFFF000.
      for (int k = 0; k < 32; k++) lut[k] = 24'hFFF000;
      frame(a, dl, dr, ll, lr);
      chk("t4_mix", {8'd0, dl}, 32'h00FF_F000);
      chk("t4_right", {8'd0, dr}, 32'h00FF_F000);
      for (int k = 0; k < 32; k++) lut[k] = 24'(k * 32'h1000);
      idle(4);

      // Test 6: reset during ISSUE of voice 2 (phases now 4x step -> 4,8,12,16).
      sample_tick_i = 1'b1;
      step_cyc();
      sample_tick_i = 1'b0;
      step_cyc();
      step_cyc();
      chk("t6_addr_v2", {27'd0, lut_addr_o}, 32'd12);
      reset_i = 1'b1;
      step_cyc();
      chk("t6_busy", {31'd0, busy_o}, 32'd0);
      chk("t6_valid", {31'd0, tx_valid_o}, 32'd0);
      chk("t6_last", {31'd0, tx_last_o}, 32'd0);
      chk("t6_data", {8'd0, tx_data_o}, 32'd0);
      chk("t6_overrun", {31'd0, overrun_o}, 32'd0);
      chk("t6_addr", {27'd0, lut_addr_o}, 32'd0);
      reset_i = 1'b0;
      idle(2);
      frame(a, dl, dr, ll, lr);
      chk("t6_f0_addrs", {12'd0, a}, 32'd0);
      chk("t6_f0_mix", {8'd0, dl}, 32'd0);
      idle(4);
      frame(a, dl, dr, ll, lr);
      chk("t6_f1_addrs", {12'd0, a}, {12'd0, 5'd4, 5'd3, 5'd2, 5'd1});
      chk("t6_f1_mix", {8'd0, dl}, 32'h0000_2800);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
